// File: rtl/ibex_rf_pkg.sv
// rtl/ibex_rf_pkg.sv - shared constants and clear-engine state type for the multi-port register file
package ibex_rf_pkg;

    localparam int unsigned RF_ADDR_W    = 5;
    localparam int unsigned RF_WORDS_MAX = 32;

    typedef enum logic [1:0] {
        RfClrIdle   = 2'd0,
        RfClrActive = 2'd1,
        RfClrDone   = 2'd2
    } rf_clr_state_e;

endpackage

// File: rtl/ibex_rf_wr_arbiter.sv
// rtl/ibex_rf_wr_arbiter.sv - per-word write decode, highest-port priority, conflict/illegal detection
module ibex_rf_wr_arbiter import ibex_rf_pkg::*; #(
    parameter bit          RV32E     = 1'b0,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned NumWrite  = 2,
    parameter int unsigned NumWords  = 32
) (
    input  logic [NumWrite*RF_ADDR_W-1:0]        waddr_i,
    input  logic [NumWrite*DataWidth-1:0]        wdata_i,
    input  logic [NumWrite-1:0]                  we_i,
    output logic [NumWords-1:1]                  word_we_o,
    output logic [NumWords-1:1][DataWidth-1:0]   word_wdata_o,
    output logic                                 conflict_o,
    output logic                                 illegal_o
);

    // Walk ports low to high so a later (higher-index) port overrides the data of an earlier hit.
    // Word 0 never matches, so writes to R0 vanish silently; addresses >= NumWords never match either.
    always_comb begin
        word_we_o    = '0;
        word_wdata_o = '0;
        conflict_o   = 1'b0;
        illegal_o    = 1'b0;
        for (int unsigned p = 0; p < NumWrite; p++) begin
            if (we_i[p] && RV32E && waddr_i[p*RF_ADDR_W + RF_ADDR_W - 1]) begin
                illegal_o = 1'b1;
            end
            for (int unsigned w = 1; w < NumWords; w++) begin
                if (we_i[p] && (waddr_i[p*RF_ADDR_W +: RF_ADDR_W] == RF_ADDR_W'(w))) begin
                    if (word_we_o[w]) begin
                        conflict_o = 1'b1;
                    end
                    word_we_o[w]    = 1'b1;
                    word_wdata_o[w] = wdata_i[p*DataWidth +: DataWidth];
                end
            end
        end
    end

endmodule

// File: rtl/ibex_register_file_mp.sv
// rtl/ibex_register_file_mp.sv - multi-read/multi-write flip-flop register file with clear engine
module ibex_register_file_mp import ibex_rf_pkg::*; #(
    parameter bit                   RV32E       = 1'b0,
    parameter int unsigned          DataWidth   = 32,
    parameter int unsigned          NumRead     = 2,
    parameter int unsigned          NumWrite    = 2,
    parameter bit                   WriteBypass = 1'b0,
    parameter logic [DataWidth-1:0] WordZeroVal = '0
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NumRead*RF_ADDR_W-1:0]   raddr_i,
    output logic [NumRead*DataWidth-1:0]   rdata_o,
    input  logic [NumWrite*RF_ADDR_W-1:0]  waddr_i,
    input  logic [NumWrite*DataWidth-1:0]  wdata_i,
    input  logic [NumWrite-1:0]            we_i,
    input  logic                           clear_req_i,
    output logic                           clear_busy_o,
    output logic                           clear_done_o,
    input  logic                           err_clr_i,
    output logic                           err_o
);

    localparam int unsigned AddrW    = RV32E ? 4 : 5;
    localparam int unsigned NumWords = 1 << AddrW;

    logic [NumWords-1:1]                word_we;
    logic [NumWords-1:1][DataWidth-1:0] word_wdata;
    logic [NumWords-1:1][DataWidth-1:0] rf_words;
    logic                               wr_conflict;
    logic                               wr_illegal;
    logic                               err_new;
    logic                               err_q;
    logic                               clr_active;
    rf_clr_state_e                      state_q, state_d;
    logic [AddrW-1:0]                   cnt_q, cnt_d;

    ibex_rf_wr_arbiter #(
        .RV32E     (RV32E),
        .DataWidth (DataWidth),
        .NumWrite  (NumWrite),
        .NumWords  (NumWords)
    ) u_wr_arbiter (
        .waddr_i      (waddr_i),
        .wdata_i      (wdata_i),
        .we_i         (we_i),
        .word_we_o    (word_we),
        .word_wdata_o (word_wdata),
        .conflict_o   (wr_conflict),
        .illegal_o    (wr_illegal)
    );

    assign clr_active = (state_q == RfClrActive);

    // Clear engine state and word counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RfClrIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Clear engine next state: sweep words 1..NumWords-1, then a single done cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            RfClrIdle: begin
                if (clear_req_i) begin
                    state_d = RfClrActive;
                    cnt_d   = AddrW'(1);
                end
            end
            RfClrActive: begin
                cnt_d = cnt_q + AddrW'(1);
                if (cnt_q == AddrW'(NumWords - 1)) begin
                    state_d = RfClrDone;
                end
            end
            RfClrDone: state_d = RfClrIdle;
            default:   state_d = RfClrIdle;
        endcase
    end

    assign clear_busy_o = clr_active;
    assign clear_done_o = (state_q == RfClrDone);

    for (genvar w = 1; w < NumWords; w++) begin : g_word
        logic [DataWidth-1:0] q;

        // One storage word; while clearing, only the counter-selected word changes and all writes are lost.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                q <= WordZeroVal;
            end else if (clr_active) begin
                if (cnt_q == AddrW'(w)) begin
                    q <= WordZeroVal;
                end
            end else if (word_we[w]) begin
                q <= word_wdata[w];
            end
        end

        assign rf_words[w] = q;
    end

    // Writes are ignored during a clear, so they cannot raise errors then either.
    assign err_new = !clr_active && (wr_conflict || wr_illegal);

    // Sticky error flag; a fresh error beats a simultaneous clear request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (err_new) begin
            err_q <= 1'b1;
        end else if (err_clr_i) begin
            err_q <= 1'b0;
        end
    end

    assign err_o = err_q;

    for (genvar k = 0; k < NumRead; k++) begin : g_read
        logic [RF_ADDR_W-1:0] ra;
        logic [AddrW-1:0]     ri;
        logic                 zero_rd;

        assign ra      = raddr_i[k*RF_ADDR_W +: RF_ADDR_W];
        assign ri      = ra[AddrW-1:0];
        assign zero_rd = (ri == '0) || (RV32E && ra[RF_ADDR_W-1]);
        assign rdata_o[k*DataWidth +: DataWidth] =
            zero_rd                                       ? WordZeroVal    :
            (WriteBypass && !clr_active && word_we[ri])   ? word_wdata[ri] :
                                                            rf_words[ri];
    end

endmodule

// File: tb/tb_ibex_register_file_mp.sv
// tb/tb_ibex_register_file_mp.sv - directed self-checking bench for ibex_register_file_mp
module tb_ibex_register_file_mp;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic [9:0]  raddr;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic [1:0]  we;
    logic        clear_req;
    logic        err_clr;

    logic [63:0] rd_a, rd_b, rd_e;
    logic        busy_a, busy_b, busy_e;
    logic        done_a, done_b, done_e;
    logic        err_a, err_b, err_e;

    int total = 0;
    int bad   = 0;
    int busy_cnt, done_cnt, busy_e_cnt;

    always #5 clk = ~clk;

    ibex_register_file_mp #(.RV32E(1'b0), .WriteBypass(1'b0)) dut_a (
        .clk_i(clk), .rst_ni(rst_ni), .raddr_i(raddr), .rdata_o(rd_a),
        .waddr_i(waddr), .wdata_i(wdata), .we_i(we), .clear_req_i(clear_req),
        .clear_busy_o(busy_a), .clear_done_o(done_a), .err_clr_i(err_clr), .err_o(err_a)
    );

    ibex_register_file_mp #(.RV32E(1'b0), .WriteBypass(1'b1)) dut_b (
        .clk_i(clk), .rst_ni(rst_ni), .raddr_i(raddr), .rdata_o(rd_b),
        .waddr_i(waddr), .wdata_i(wdata), .we_i(we), .clear_req_i(clear_req),
        .clear_busy_o(busy_b), .clear_done_o(done_b), .err_clr_i(err_clr), .err_o(err_b)
    );

    ibex_register_file_mp #(.RV32E(1'b1), .WriteBypass(1'b0)) dut_e (
        .clk_i(clk), .rst_ni(rst_ni), .raddr_i(raddr), .rdata_o(rd_e),
        .waddr_i(waddr), .wdata_i(wdata), .we_i(we), .clear_req_i(clear_req),
        .clear_busy_o(busy_e), .clear_done_o(done_e), .err_clr_i(err_clr), .err_o(err_e)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        raddr = {a1, a0};
    endtask

    task automatic wr(input logic [4:0] a0, input logic [31:0] d0,
                      input logic [4:0] a1, input logic [31:0] d1, input logic [1:0] en);
        waddr = {a1, a0};
        wdata = {d1, d0};
        we    = en;
    endtask

    initial begin
        rst_ni    = 1'b0;
        clear_req = 1'b0;
        err_clr   = 1'b0;
        rd(5'd5, 5'd0);
        wr(5'd0, 32'h0, 5'd0, 32'h0, 2'b00);
        step();
        step();
        check("rst_busy", {31'd0, busy_a}, 32'd0);
        check("rst_done", {31'd0, done_a}, 32'd0);
        check("rst_err", {31'd0, err_a}, 32'd0);
        check("rst_x5", rd_a[31:0], 32'h0);
        rst_ni = 1'b1;
        step();

        // write x5 through port 0; bypass instance forwards it the same cycle
        wr(5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 2'b01);
        #1;
        check("nobp_same_cycle", rd_a[31:0], 32'h0);
        check("bp_same_cycle", rd_b[31:0], 32'hDEADBEEF);
        step();
        wr(5'd0, 32'h0, 5'd0, 32'h0, 2'b00);
        #1;
        check("wr_x5", rd_a[31:0], 32'hDEADBEEF);
        check("rd_x0", rd_a[63:32], 32'h0);
        check("wr_no_err", {31'd0, err_a}, 32'd0);

        // both ports hit x7: port 1 wins, error raised and held
        wr(5'd7, 32'h11, 5'd7, 32'h22, 2'b11);
        step();
        wr(5'd0, 32'h0, 5'd0, 32'h0, 2'b00);
        rd(5'd7, 5'd0);
        #1;
        check("conf_data", rd_a[31:0], 32'h22);
        check("conf_err", {31'd0, err_a}, 32'd1);
        step();
        check("conf_err_sticky", {31'd0, err_a}, 32'd1);
        err_clr = 1'b1;
        wr(5'd7, 32'h33, 5'd7, 32'h44, 2'b11);
        step();
        check("err_new_beats_clr", {31'd0, err_a}, 32'd1);
        check("conf_data2", rd_a[31:0], 32'h44);
        wr(5'd0, 32'h0, 5'd0, 32'h0, 2'b00);
        step();
        err_clr = 1'b0;
        check("err_cleared", {31'd0, err_a}, 32'd0);

        // port 1 writes x3, port 0 writes x0; R0 never bypasses and raises no error
        rd(5'd3, 5'd0);
        wr(5'd0, 32'hFFFF, 5'd3, 32'hA5A5, 2'b11);
        #1;
        check("bp_x3", rd_b[31:0], 32'hA5A5);
        check("nobp_x3_old", rd_a[31:0], 32'h0);
        check("bp_r0", rd_b[63:32], 32'h0);
        step();
        wr(5'd0, 32'h0, 5'd0, 32'h0, 2'b00);
        #1;
        check("x3_stored", rd_a[31:0], 32'hA5A5);
        check("r0_no_err", {31'd0, err_b}, 32'd0);

        // address 17: illegal on the RV32E instance, ordinary on the full one
        wr(5'd17, 32'h1234, 5'd0, 32'h0, 2'b01);
        step();
        wr(5'd0, 32'h0, 5'd0, 32'h0, 2'b00);
        rd(5'd17, 5'd1);
        #1;
        check("e_err", {31'd0, err_e}, 32'd1);
        check("e_rd17", rd_e[31:0], 32'h0);
        check("e_x1_untouched", rd_e[63:32], 32'h0);
        check("a_x17", rd_a[31:0], 32'h1234);
        check("a_no_err", {31'd0, err_a}, 32'd0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("e_err_cleared", {31'd0, err_e}, 32'd0);

        // fill x1..x31 with their own index
        for (int i = 1; i < 32; i += 2) begin
            if (i == 31) wr(5'(i), 32'(i), 5'd0, 32'h0, 2'b01);
            else         wr(5'(i), 32'(i), 5'(i + 1), 32'(i + 1), 2'b11);
            step();
        end
        wr(5'd0, 32'h0, 5'd0, 32'h0, 2'b00);
        rd(5'd31, 5'd16);
        #1;
        check("fill_x31", rd_a[31:0], 32'd31);
        check("fill_x16", rd_a[63:32], 32'd16);

        // clear sweep; writes attempted while busy must be lost
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        rd(5'd1, 5'd31);
        busy_cnt = 0; done_cnt = 0; busy_e_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (c == 0)  check("clr_x1_c1", rd_a[31:0], 32'd1);
            if (c == 1)  check("clr_x1_c2", rd_a[31:0], 32'd0);
            if (c == 29) check("clr_x31_c30", rd_a[63:32], 32'd31);
            if (c == 30) check("clr_x31_c31", rd_a[63:32], 32'd31);
            if (busy_a) busy_cnt++;
            if (done_a) done_cnt++;
            if (busy_e) busy_e_cnt++;
            if (busy_a) wr(5'd31, 32'hBAD, 5'd2, 32'hBAD, 2'b11);
            else        wr(5'd0, 32'h0, 5'd0, 32'h0, 2'b00);
            step();
        end
        check("clr_busy_cycles", busy_cnt, 32'd31);
        check("clr_done_pulses", done_cnt, 32'd1);
        check("clr_e_busy_cycles", busy_e_cnt, 32'd15);
        rd(5'd2, 5'd31);
        #1;
        check("clr_x2", rd_a[31:0], 32'h0);
        check("clr_x31", rd_a[63:32], 32'h0);

        // reset part way through a clear
        wr(5'd20, 32'h20, 5'd0, 32'h0, 2'b01);
        step();
        wr(5'd0, 32'h0, 5'd0, 32'h0, 2'b00);
        rd(5'd20, 5'd0);
        #1;
        check("pre_x20", rd_a[31:0], 32'h20);
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        repeat (9) step();
        check("mid_busy", {31'd0, busy_a}, 32'd1);
        rst_ni = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, busy_a}, 32'd0);
        check("mid_rst_x20", rd_a[31:0], 32'h0);
        step();
        rst_ni = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 35; c++) begin
            if (done_a || busy_a) done_cnt++;
            step();
        end
        check("mid_rst_no_done", done_cnt, 32'd0);
        wr(5'd20, 32'h77, 5'd0, 32'h0, 2'b01);
        step();
        wr(5'd0, 32'h0, 5'd0, 32'h0, 2'b00);
        #1;
        check("post_rst_wr", rd_a[31:0], 32'h77);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
